avalon_mm_arbiter: RTL
======================

Name: avalon_mm_arbiter

Overview:
- Shares one Avalon-MM slave port between NUM_MASTERS requesters, e.g. several avalon_master/avalon_driver instances driving one DUT slave.
- Uses round-robin arbitration with one transfer per grant.
- Uses the same signal set as the driver: address, read, write, writedata, readdata, waitrequest. There is no readdatavalid; read data is valid in the cycle waitrequest is low.
- Sits between the requester ports and the slave in both VIP benches and RTL interconnect.

Parameters:
- NUM_MASTERS, 4: number of requesters, 2..16.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1: single clock.
- reset  in  1: synchronous, active-high reset.
- req_address  in  NUM_MASTERS*ADDR_W: per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_read  in  NUM_MASTERS: per-requester read strobe.
- req_write  in  NUM_MASTERS: per-requester write strobe.
- req_writedata  in  NUM_MASTERS*DATA_W: per-requester write data.
- req_readdata  out  DATA_W: slave readdata, broadcast to all requesters.
- req_waitrequest  out  NUM_MASTERS: per-requester waitrequest.
- avm_address  out  ADDR_W: slave address.
- avm_read  out  1: slave read.
- avm_write  out  1: slave write.
- avm_writedata  out  DATA_W: slave write data.
- avm_readdata  in  DATA_W: slave read data.
- avm_waitrequest  in  1: slave waitrequest.
- grant  out  NUM_MASTERS: one-hot current owner, all-zero when idle.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, grant=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, req_waitrequest=all ones, last_grant pointer=NUM_MASTERS-1 (so requester 0 wins first).
- A requester is pending when req_read[i] or req_write[i] is high.
- IDLE:
  - Each cycle, evaluate pending requesters in round-robin order starting at last_grant+1, wrapping at NUM_MASTERS.
  - On any pending request, register one-hot grant and move to BUSY.
  - The slave is not driven in the arbitration cycle.
  - With no pending request, stay in IDLE.
- BUSY:
  - avm_* are driven combinationally from the granted requester's address, write data and strobes.
  - req_waitrequest[g] = avm_waitrequest. All other requesters see waitrequest=1.
  - req_readdata = avm_readdata, passed combinationally.
  - The transfer completes in the cycle avm_waitrequest=0 with avm_read or avm_write high.
  - On completion, at the next edge: last_grant becomes g, grant clears, and the state returns to IDLE.
- Latency:
  - One arbitration cycle plus the slave's wait states.
  - Minimum 2 cycles per transfer.
  - The back-to-back ceiling is one transfer per 2 cycles.
- Boundary: granted requester drops both strobes in BUSY (abort). Release to IDLE at the next edge, leave last_grant unchanged, and issue no slave strobe in that cycle.
- Boundary: read and write both high on the granted requester. This is a protocol violation; forward the write only (avm_read=0), and the transfer completes as a write.
- Boundary: a requester asserts while another is in BUSY. It stays pending with waitrequest=1 and is considered at the next IDLE.
- Boundary: only one requester is pending repeatedly. It wins every arbitration; there is no idle penalty beyond the arbitration cycle.
- Boundary: reset mid-transfer. All outputs return to reset values at the next edge; the in-flight transfer is dropped with no completion.
- Boundary: last_grant = NUM_MASTERS-1. The search wraps to requester 0.

Optional Feature:
- Macro: AVALON_ARB_LOCK_EN.
- Enabled:
  - Adds input req_lock[NUM_MASTERS].
  - If req_lock[g] is high in the completion cycle, the FSM stays in BUSY with the grant held.
  - This gives one transfer per cycle for a locked burst with zero-wait slaves.
  - The grant is released on the first completion with req_lock[g]=0, or on abort.
- Disabled: the port is absent and the grant is always released after one transfer.

Decomposition:
- Shared package avalon_arb_pkg:
  - State encoding localparams ST_IDLE and ST_BUSY.
  - Default ADDR_W and DATA_W.
  - Function for one-hot to index conversion.
- Sub-module rr_arbiter:
  - Purely combinational round-robin picker.
  - Inputs: request vector, last_grant index.
  - Outputs: one-hot winner, winner index, any_req.
  - Reused elsewhere for streaming muxes.

Test Plan:
- Reset release, no requests -> grant=0, avm_read=0, avm_write=0, req_waitrequest=4'b1111 held for 10 cycles.
- Reset release, all 4 requesters write continuously, slave avm_waitrequest=0 -> grants in order 0,1,2,3,0, one completion every 2 cycles, each avm_address matches the granted requester.
- Requester 2 reads 0x100 while the slave holds avm_waitrequest high for 3 cycles, slave then returns 0xDEADBEEF -> req_waitrequest[2] low only in the completion cycle, req_readdata=0xDEADBEEF, others stay 1.
- Requester 1 granted, drops read before completion -> FSM back to IDLE next cycle, last_grant unchanged, requester 0 pending wins next.
- Assert reset during BUSY with avm_waitrequest=1 -> next edge grant=0, avm_write=0, state IDLE, no completion reported.
- With AVALON_ARB_LOCK_EN, requester 3 issues 4 writes with req_lock=1 on the first 3, zero-wait slave -> 4 consecutive-cycle transfers, grant released after the 4th, then requester 0 is served.

Source files
------------

// File: rtl/avalon_arb_pkg.sv
// Shared definitions for the Avalon-MM arbiter: FSM state codes, default bus
// widths and a one-hot to index helper (requester counts up to 16).
package avalon_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant
// (wrapping at N) wins. Shared with the streaming mux blocks.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     gnt_oh,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'(v % N);
    endfunction

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any_req = 1'b0;
        for (int off = 1; off <= N; off++) begin
            if (!any_req && req[wrap_idx(int'(last_grant) + off)]) begin
                any_req                                   = 1'b1;
                gnt_oh[wrap_idx(int'(last_grant) + off)]  = 1'b1;
                gnt_idx                                   = wrap_idx(int'(last_grant) + off);
            end
        end
    end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Round-robin sharing of one Avalon-MM slave among NUM_MASTERS requesters, one
// transfer per grant. Define AVALON_ARB_LOCK_EN to add req_lock burst holding.
module avalon_mm_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0] req_address,
    input  logic [NUM_MASTERS-1:0]        req_read,
    input  logic [NUM_MASTERS-1:0]        req_write,
    input  logic [NUM_MASTERS*DATA_W-1:0] req_writedata,
`ifdef AVALON_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0]        req_lock,
`endif
    output logic [DATA_W-1:0]             req_readdata,
    output logic [NUM_MASTERS-1:0]        req_waitrequest,
    output logic [ADDR_W-1:0]             avm_address,
    output logic                          avm_read,
    output logic                          avm_write,
    output logic [DATA_W-1:0]             avm_writedata,
    input  logic [DATA_W-1:0]             avm_readdata,
    input  logic                          avm_waitrequest,
    output logic [NUM_MASTERS-1:0]        grant
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [0:0]             state;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IDX_W-1:0]       g_idx;
    logic [IDX_W-1:0]       last_grant;

    logic [NUM_MASTERS-1:0] pending;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic [IDX_W-1:0]       pick_idx;
    logic                   any_req;
    logic                   busy, g_rd, g_wr, complete, abort, lock_hold;

    assign pending  = req_read | req_write;
    assign busy     = (state == ST_BUSY);
    assign g_rd     = req_read[g_idx];
    assign g_wr     = req_write[g_idx];
    assign complete = busy & (g_rd | g_wr) & ~avm_waitrequest;
    assign abort    = busy & ~(g_rd | g_wr);

`ifdef AVALON_ARB_LOCK_EN
    assign lock_hold = req_lock[g_idx];
`else
    assign lock_hold = 1'b0;
`endif

    rr_arbiter #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_rr (
        .req        (pending),
        .last_grant (last_grant),
        .gnt_oh     (pick_oh),
        .gnt_idx    (pick_idx),
        .any_req    (any_req)
    );

    // Read+write together is a protocol violation: the write takes priority.
    always_comb begin
        avm_address     = '0;
        avm_writedata   = '0;
        avm_read        = 1'b0;
        avm_write       = 1'b0;
        req_waitrequest = '1;
        if (busy) begin
            avm_address            = req_address[g_idx*ADDR_W +: ADDR_W];
            avm_writedata          = req_writedata[g_idx*DATA_W +: DATA_W];
            avm_write              = g_wr;
            avm_read               = g_rd & ~g_wr;
            req_waitrequest[g_idx] = avm_waitrequest;
        end
    end

    assign req_readdata = avm_readdata;
    assign grant        = grant_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            g_idx      <= '0;
            last_grant <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state   <= ST_BUSY;
                        grant_q <= pick_oh;
                        g_idx   <= pick_idx;
                    end
                end
                default: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        grant_q <= '0;
                    end else if (complete) begin
                        last_grant <= g_idx;
                        if (!lock_hold) begin
                            state   <= ST_IDLE;
                            grant_q <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
